pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline (IF, ID, EX, MEM, WB). Collects hazard and wait requests (load-use stop from the forwarding logic, fetch wait, data-memory wait, multi-cycle divider, committed exception) and produces a consistent set of per-register enables and bubble injects. It also owns the divider launch handshake and a stall-cycle performance counter. Sits beside the forwarding unit; its outputs drive the PC and the four inter-stage pipeline registers.

## Interface
- No parameters.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, synchronous, active-low
- load_use_stall  in  1  load-use hazard at ID (forwarding unit stop)
- if_wait  in  1  instruction fetch not ready this cycle
- mem_wait  in  1  data memory access in MEM not complete this cycle
- ex_div_op  in  1  valid DIV/DIVU currently in EX
- div_done  in  1  divider result valid, 1-cycle pulse
- exc_commit  in  1  exception/ERET taken at MEM this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble (valid=0) on this edge
- pc_sel_exc  out  1  PC loads exception/EPC vector
- div_start  out  1  launch divider, 1-cycle pulse
- div_cancel  out  1  abort in-flight divide, 1-cycle pulse
- ctrl_state  out  2  FSM state: 0 RUN, 1 DIV, 2 DHOLD
- stall_cycles  out  32  count of cycles with pc_en=0 while rst=1

## Operation
- Flush has priority over enable for the same register; a flushed register is always also enabled.
- Stall at stage S: PC and registers upstream of S hold; the register directly downstream of S is flushed; registers further downstream advance.
- Priority (highest first), evaluated every cycle:
  1. exc_commit: pc_en=1, pc_sel_exc=1; flush if_id, id_ex, ex_mem, mem_wb. div_cancel=1 if state is DIV or DHOLD; next state RUN.
  2. mem_wait: hold PC, if_id, id_ex, ex_mem; flush mem_wb.
  3. Divide busy (state DIV, or RUN with ex_div_op): hold PC, if_id, id_ex; flush ex_mem.
  4. load_use_stall: hold PC, if_id; flush id_ex.
  5. if_wait: hold PC; flush if_id.
  6. Otherwise all enables 1, all flushes 0.
- FSM:
  - RUN: ex_div_op & ~mem_wait & ~exc_commit -> div_start=1, go DIV.
  - DIV: div_done & ~mem_wait & ~exc_commit -> go RUN with the divide-complete cycle treated as not busy (rule 3 inactive, EX advances). div_done & mem_wait -> go DHOLD. exc_commit -> RUN.
  - DHOLD: result held, no new div_start, rule 3 inactive. ~mem_wait -> RUN, EX advances. exc_commit -> RUN.
- Branch delay slots: no branch flush; taken branches are not visible to this block.
- stall_cycles increments by 1 on each edge where rst=1 and pc_en=0, wrapping from 0xFFFFFFFF to 0.

## Timing
- All control outputs are combinational from state and current inputs. ctrl_state and stall_cycles are registered.
- div_start is asserted in the same cycle ex_div_op is first seen in RUN. Asserted at most once per divide instruction.
- Minimum divide stall = divider latency + 0 cycles. EX/MEM loads the result on the div_done edge.
- While rst=0:
  - Enables are 0 and flushes are 1.
  - pc_sel_exc, div_start and div_cancel are 0.
  - On the edge: state goes to RUN and stall_cycles to 0.
- Reset mid-divide: state returns to RUN. div_cancel is not required, and the divider is reset by the same rst.
- Simultaneous events:
  - div_done together with exc_commit: the result is discarded, and div_cancel is still pulsed.
  - load_use_stall together with if_wait: load-use handling applies. The PC and if_id hold, so the fetch is retried.

## Test plan
- Reset: hold rst=0 for 3 cycles with all inputs at 1 -> every enable 0, every flush 1, div_start 0, ctrl_state 0, stall_cycles 0 after release.
- Load-use: single-cycle load_use_stall=1 -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle; stall_cycles increments 0->1.
- Divide: ex_div_op=1, div_done 5 cycles later.
  - div_start pulses once in cycle 0 and ctrl_state=1 for cycles 1-5.
  - ex_mem_flush=1 for cycles 0-4; in cycle 5, ex_mem_en=1 and ex_mem_flush=0.
  - State returns to 0 afterwards.
- Divide plus memory wait: div_done arrives while mem_wait=1 for 3 cycles -> state DHOLD, no second div_start, mem_wb_flush=1 for those 3 cycles, then EX advances in the first cycle with mem_wait=0.
- Exception during divide: exc_commit=1 in DIV state -> div_cancel=1, pc_sel_exc=1, all four flushes 1, pc_en=1, next ctrl_state 0.
- Counter wrap: preload via 2^32 stalled cycles or a force -> stall_cycles goes 0xFFFFFFFF -> 0x00000000.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Hazard/wait requests from the pipeline and the stall, flush and divider
// controls returned by the sequencer.
interface pipeline_ctrl_if;
    logic        load_use_stall;
    logic        if_wait;
    logic        mem_wait;
    logic        ex_div_op;
    logic        div_done;
    logic        exc_commit;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        mem_wb_flush;
    logic        pc_sel_exc;
    logic        div_start;
    logic        div_cancel;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cycles;

    modport master (
        output load_use_stall, if_wait, mem_wait, ex_div_op, div_done, exc_commit,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
        input  pc_sel_exc, div_start, div_cancel, ctrl_state, stall_cycles
    );

    modport slave (
        input  load_use_stall, if_wait, mem_wait, ex_div_op, div_done, exc_commit,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
        output pc_sel_exc, div_start, div_cancel, ctrl_state, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: per-register enables,
// bubble injects, divider launch handshake and a stall-cycle counter.
//
// state | meaning
// RUN   | no divide outstanding
// DIV   | divider launched, waiting for div_done
// DHOLD | divide result ready but MEM still waiting; EX holds the result
module pipeline_ctrl (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave ctrl_if
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DIV   = 2'd1,
        DHOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        div_busy;
    logic        start_ok;
    logic        pc_en;
    logic        pc_sel;
    logic        cancel;
    // Bit order: [3] if_id, [2] id_ex, [1] ex_mem, [0] mem_wb
    logic [3:0]  reg_en;
    logic [3:0]  reg_flush;

    always_comb begin
        div_busy = ((state_q == DIV) && !ctrl_if.div_done) ||
                   ((state_q == RUN) && ctrl_if.ex_div_op);
        start_ok = rst && (state_q == RUN) && ctrl_if.ex_div_op &&
                   !ctrl_if.mem_wait && !ctrl_if.exc_commit;

        pc_en     = 1'b1;
        reg_en    = 4'b1111;
        reg_flush = 4'b0000;
        pc_sel    = 1'b0;
        cancel    = 1'b0;

        if (!rst) begin
            pc_en     = 1'b0;
            reg_en    = 4'b0000;
            reg_flush = 4'b1111;
        end else if (ctrl_if.exc_commit) begin
            reg_flush = 4'b1111;
            pc_sel    = 1'b1;
            cancel    = (state_q != RUN);
        end else if (ctrl_if.mem_wait) begin
            pc_en     = 1'b0;
            reg_en    = 4'b0001;
            reg_flush = 4'b0001;
        end else if (div_busy) begin
            pc_en     = 1'b0;
            reg_en    = 4'b0011;
            reg_flush = 4'b0010;
        end else if (ctrl_if.load_use_stall) begin
            pc_en     = 1'b0;
            reg_en    = 4'b0111;
            reg_flush = 4'b0100;
        end else if (ctrl_if.if_wait) begin
            pc_en     = 1'b0;
            reg_flush = 4'b1000;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (start_ok)
                    state_d = DIV;
            end
            DIV: begin
                if (ctrl_if.exc_commit)
                    state_d = RUN;
                else if (ctrl_if.div_done)
                    state_d = ctrl_if.mem_wait ? DHOLD : RUN;
            end
            DHOLD: begin
                if (ctrl_if.exc_commit || !ctrl_if.mem_wait)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        stall_cnt_d = pc_en ? stall_cnt_q : stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ctrl_if.pc_en        = pc_en;
    assign ctrl_if.if_id_en     = reg_en[3];
    assign ctrl_if.id_ex_en     = reg_en[2];
    assign ctrl_if.ex_mem_en    = reg_en[1];
    assign ctrl_if.mem_wb_en    = reg_en[0];
    assign ctrl_if.if_id_flush  = reg_flush[3];
    assign ctrl_if.id_ex_flush  = reg_flush[2];
    assign ctrl_if.ex_mem_flush = reg_flush[1];
    assign ctrl_if.mem_wb_flush = reg_flush[0];
    assign ctrl_if.pc_sel_exc   = pc_sel;
    assign ctrl_if.div_start    = start_ok;
    assign ctrl_if.div_cancel   = cancel;
    assign ctrl_if.ctrl_state   = state_q;
    assign ctrl_if.stall_cycles = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized requests
// checked against a stage-priority reference model.
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt;

    pipeline_ctrl_if bus ();

    pipeline_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (bus)
    );

    always #5 clk = ~clk;

    // {pc_en, 4 enables, 4 flushes, pc_sel_exc, div_start, div_cancel}
    logic [11:0] act;
    assign act = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                  bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush,
                  bus.pc_sel_exc, bus.div_start, bus.div_cancel};

    localparam logic [11:0] ALL_RUN = 12'b1_1111_0000_000;

    task automatic set_in(input logic lu, input logic ifw, input logic mw,
                          input logic dop, input logic dd, input logic exc);
        bus.load_use_stall = lu;
        bus.if_wait        = ifw;
        bus.mem_wait       = mw;
        bus.ex_div_op      = dop;
        bus.div_done       = dd;
        bus.exc_commit     = exc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(1, 1, 1, 1, 1, 1);
        for (int c = 0; c < 3; c++) begin
            total++;
            if (act !== 12'b0_0000_1111_000) begin
                bad++;
                $display("FAIL reset_out cycle %0d: got %b want %b", c, act, 12'b0_0000_1111_000);
            end
            tick();
        end
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        total++;
        if (bus.ctrl_state !== 2'd0 || bus.stall_cycles !== 32'd0) begin
            bad++;
            $display("FAIL reset_regs: got state=%0d cnt=%0d want state=0 cnt=0",
                     bus.ctrl_state, bus.stall_cycles);
        end
        total++;
        if (act !== ALL_RUN) begin
            bad++;
            $display("FAIL reset_release: got %b want %b", act, ALL_RUN);
        end
        exp_cnt = 0;
    endtask

    task automatic test_load_use();
        set_in(1, 0, 0, 0, 0, 0);
        total++;
        if (act !== 12'b0_0111_0100_000) begin
            bad++;
            $display("FAIL load_use: got %b want %b", act, 12'b0_0111_0100_000);
        end
        tick();
        exp_cnt += 1;
        set_in(0, 0, 0, 0, 0, 0);
        total++;
        if (act !== ALL_RUN || bus.stall_cycles !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL load_use_after: got %b cnt=%0d want %b cnt=%0d",
                     act, bus.stall_cycles, ALL_RUN, exp_cnt);
        end
        // load-use together with if_wait: load-use handling wins
        set_in(1, 1, 0, 0, 0, 0);
        total++;
        if (act !== 12'b0_0111_0100_000) begin
            bad++;
            $display("FAIL load_use_ifwait: got %b want %b", act, 12'b0_0111_0100_000);
        end
        tick();
        exp_cnt += 1;
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_divide();
        set_in(0, 0, 0, 1, 0, 0);
        total++;
        if (act !== 12'b0_0011_0010_010 || bus.ctrl_state !== 2'd0) begin
            bad++;
            $display("FAIL div_c0: got %b state=%0d want %b state=0",
                     act, bus.ctrl_state, 12'b0_0011_0010_010);
        end
        tick();
        for (int c = 1; c < 5; c++) begin
            set_in(0, 0, 0, 1, 0, 0);
            total++;
            if (act !== 12'b0_0011_0010_000 || bus.ctrl_state !== 2'd1) begin
                bad++;
                $display("FAIL div_wait cycle %0d: got %b state=%0d want %b state=1",
                         c, act, bus.ctrl_state, 12'b0_0011_0010_000);
            end
            tick();
        end
        set_in(0, 0, 0, 1, 1, 0);
        total++;
        if (act !== ALL_RUN || bus.ctrl_state !== 2'd1) begin
            bad++;
            $display("FAIL div_done: got %b state=%0d want %b state=1",
                     act, bus.ctrl_state, ALL_RUN);
        end
        tick();
        exp_cnt += 5;
        set_in(0, 0, 0, 0, 0, 0);
        total++;
        if (bus.ctrl_state !== 2'd0 || bus.stall_cycles !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL div_end: got state=%0d cnt=%0d want state=0 cnt=%0d",
                     bus.ctrl_state, bus.stall_cycles, exp_cnt);
        end
    endtask

    task automatic test_div_memwait();
        set_in(0, 0, 0, 1, 0, 0);
        tick();
        for (int c = 1; c < 3; c++) begin
            set_in(0, 0, 0, 1, 0, 0);
            tick();
        end
        for (int c = 3; c < 6; c++) begin
            set_in(0, 0, 1, 1, (c == 3) ? 1'b1 : 1'b0, 0);
            total++;
            if (act !== 12'b0_0001_0001_000 ||
                bus.ctrl_state !== ((c == 3) ? 2'd1 : 2'd2)) begin
                bad++;
                $display("FAIL div_memwait cycle %0d: got %b state=%0d want %b state=%0d",
                         c, act, bus.ctrl_state, 12'b0_0001_0001_000, (c == 3) ? 1 : 2);
            end
            tick();
        end
        set_in(0, 0, 0, 1, 0, 0);
        total++;
        if (act !== ALL_RUN || bus.ctrl_state !== 2'd2) begin
            bad++;
            $display("FAIL dhold_release: got %b state=%0d want %b state=2",
                     act, bus.ctrl_state, ALL_RUN);
        end
        tick();
        exp_cnt += 6;
        set_in(0, 0, 0, 0, 0, 0);
        total++;
        if (bus.ctrl_state !== 2'd0 || bus.stall_cycles !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL dhold_end: got state=%0d cnt=%0d want state=0 cnt=%0d",
                     bus.ctrl_state, bus.stall_cycles, exp_cnt);
        end
    endtask

    task automatic test_exc_div();
        set_in(0, 0, 0, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 1, 1);
        total++;
        if (act !== 12'b1_1111_1111_101 || bus.ctrl_state !== 2'd1) begin
            bad++;
            $display("FAIL exc_div: got %b state=%0d want %b state=1",
                     act, bus.ctrl_state, 12'b1_1111_1111_101);
        end
        tick();
        exp_cnt += 1;
        set_in(0, 0, 0, 0, 0, 0);
        total++;
        if (bus.ctrl_state !== 2'd0 || bus.stall_cycles !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL exc_div_after: got state=%0d cnt=%0d want state=0 cnt=%0d",
                     bus.ctrl_state, bus.stall_cycles, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        #1;
        total++;
        if (bus.stall_cycles !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL wrap_preload: got %h want ffffffff", bus.stall_cycles);
        end
        set_in(0, 1, 0, 0, 0, 0);
        total++;
        if (act !== 12'b0_1111_1000_000) begin
            bad++;
            $display("FAIL if_wait: got %b want %b", act, 12'b0_1111_1000_000);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        total++;
        if (bus.stall_cycles !== 32'h0000_0000) begin
            bad++;
            $display("FAIL wrap: got %h want 00000000", bus.stall_cycles);
        end
    endtask

    task automatic test_random();
        int          phase;   // 0 no divide, 1 divider running, 2 result parked in EX
        logic [31:0] m_cnt;
        logic        r, lu, ifw, mw, dop, dd, exc, busy, pe, start, cncl;
        logic [4:1]  en, fl;
        logic [11:0] exp_v;
        int          s;

        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        phase = 0;
        m_cnt = 32'd0;
        for (int c = 0; c < 600; c++) begin
            r   = ($urandom_range(0, 39) != 0);
            lu  = ($urandom_range(0, 3) == 0);
            ifw = ($urandom_range(0, 3) == 0);
            mw  = ($urandom_range(0, 3) == 0);
            dop = ($urandom_range(0, 2) == 0);
            dd  = ($urandom_range(0, 4) == 0);
            exc = ($urandom_range(0, 11) == 0);
            rst = r;
            set_in(lu, ifw, mw, dop, dd, exc);

            busy  = (phase == 1 && !dd) || (phase == 0 && dop);
            start = r && !exc && !mw && phase == 0 && dop;
            cncl  = r && exc && phase != 0;
            if (!r) begin
                pe = 1'b0; en = 4'b0000; fl = 4'b1111;
            end else if (exc) begin
                pe = 1'b1; en = 4'b1111; fl = 4'b1111;
            end else begin
                // stalled stage: 4 MEM, 3 EX, 2 ID, 1 IF, 0 none
                s  = mw ? 4 : busy ? 3 : lu ? 2 : ifw ? 1 : 0;
                pe = (s == 0);
                for (int k = 1; k <= 4; k++) begin
                    en[k] = (s == 0) || (k >= s);
                    fl[k] = (k == s);
                end
            end
            exp_v = {pe, en[1], en[2], en[3], en[4], fl[1], fl[2], fl[3], fl[4],
                     r && exc, start, cncl};

            total++;
            if (act !== exp_v || bus.ctrl_state !== 2'(phase) || bus.stall_cycles !== m_cnt) begin
                bad++;
                $display("FAIL rand cycle %0d: got %b state=%0d cnt=%0d want %b state=%0d cnt=%0d",
                         c, act, bus.ctrl_state, bus.stall_cycles, exp_v, phase, m_cnt);
            end
            tick();

            if (!r) begin
                phase = 0;
                m_cnt = 32'd0;
            end else begin
                if (!pe)
                    m_cnt = m_cnt + 32'd1;
                if (exc)
                    phase = 0;
                else if (phase == 0)
                    phase = start ? 1 : 0;
                else if (phase == 1)
                    phase = dd ? (mw ? 2 : 0) : 1;
                else
                    phase = mw ? 2 : 0;
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_load_use();
        test_divide();
        test_div_memwait();
        test_exc_div();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
